// File: rtl/stochastic_stream_engine.sv
// Multi-channel stochastic-computing stream engine: LFSR comparators feed a per-channel AND/MUX/XOR/pass
// combiner whose 1-bits are counted over a len-cycle run. Optional macro SC_STREAM_TAP_EN exposes the raw bits.
module stochastic_stream_engine #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int LEN_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEN_W-1:0]          len,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] prob_a,
  input  logic [CHANNELS*WIDTH-1:0] prob_b,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [CHANNELS*LEN_W-1:0] result
`ifdef SC_STREAM_TAP_EN
  ,
  output logic [CHANNELS-1:0]       stream_bits,
  output logic                      stream_valid
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] remain_reg;
  logic [1:0]       mode_reg;
  logic [15:0]      sel_lfsr_reg;
  logic             err_reg;
  logic             accept;
  logic             reject_zero;

  // Odd multiplier keeps every seed nonzero and distinct across all 2*CHANNELS+1 generators.
  function automatic logic [15:0] seed(input int idx);
    logic [31:0] s;
    s = 32'(idx + 1) * 32'h0000_9E37;
    return s[15:0];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign accept      = (state_reg == IDLE) && start && (len != '0);
  assign reject_zero = (state_reg == IDLE) && start && (len == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (abort)                         state_next = IDLE;
        else if (remain_reg == LEN_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg      <= 1'b0;
      remain_reg   <= '0;
      mode_reg     <= 2'b00;
      sel_lfsr_reg <= seed(2 * CHANNELS);
    end else begin
      if (reject_zero) err_reg <= 1'b1;
      if (accept) begin
        remain_reg   <= len;
        mode_reg     <= mode;
        sel_lfsr_reg <= seed(2 * CHANNELS);
      end else if (state_reg == RUN) begin
        remain_reg   <= remain_reg - LEN_W'(1);
        sel_lfsr_reg <= lfsr_step(sel_lfsr_reg);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [15:0]      lfsr_a_reg, lfsr_b_reg;
      logic [WIDTH-1:0] pa_reg, pb_reg;
      logic [LEN_W-1:0] count_reg;
      logic             bit_a, bit_b, mixed;

      // Strict compare: probability 0 can never produce a 1.
      assign bit_a = lfsr_a_reg[15 -: WIDTH] < pa_reg;
      assign bit_b = lfsr_b_reg[15 -: WIDTH] < pb_reg;

      always_comb begin
        mixed = bit_a;
        case (mode_reg)
          2'b00:   mixed = bit_a & bit_b;
          2'b01:   mixed = sel_lfsr_reg[15] ? bit_b : bit_a;
          2'b10:   mixed = bit_a ^ bit_b;
          default: mixed = bit_a;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lfsr_a_reg <= seed(2 * gi);
          lfsr_b_reg <= seed(2 * gi + 1);
          pa_reg     <= '0;
          pb_reg     <= '0;
          count_reg  <= '0;
        end else if (accept) begin
          lfsr_a_reg <= seed(2 * gi);
          lfsr_b_reg <= seed(2 * gi + 1);
          pa_reg     <= prob_a[gi*WIDTH +: WIDTH];
          pb_reg     <= prob_b[gi*WIDTH +: WIDTH];
          count_reg  <= '0;
        end else if (state_reg == RUN) begin
          lfsr_a_reg <= lfsr_step(lfsr_a_reg);
          lfsr_b_reg <= lfsr_step(lfsr_b_reg);
          count_reg  <= count_reg + LEN_W'(mixed);
        end
      end

      assign result[gi*LEN_W +: LEN_W] = count_reg;
`ifdef SC_STREAM_TAP_EN
      assign stream_bits[gi] = mixed;
`endif
    end
  endgenerate

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign err  = err_reg;
`ifdef SC_STREAM_TAP_EN
  assign stream_valid = (state_reg == RUN);
`endif

endmodule

// File: tb/tb_stochastic_stream_engine.sv
// Randomized bench for stochastic_stream_engine: cycle-level timing model, statistical bounds,
// and determinism/prefix relations between runs (a run aborted after k cycles equals a k-cycle run).
module tb_stochastic_stream_engine;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int LEN_W    = 16;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic                      abort = 1'b0;
  logic [LEN_W-1:0]          len = '0;
  logic [1:0]                mode = 2'b00;
  logic [CHANNELS*WIDTH-1:0] prob_a = '0;
  logic [CHANNELS*WIDTH-1:0] prob_b = '0;
  logic                      busy, done, err;
  logic [CHANNELS*LEN_W-1:0] result;
`ifdef SC_STREAM_TAP_EN
  logic [CHANNELS-1:0]       stream_bits;
  logic                      stream_valid;
`endif

  stochastic_stream_engine #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len), .mode(mode),
    .prob_a(prob_a), .prob_b(prob_b), .busy(busy), .done(done), .err(err), .result(result)
`ifdef SC_STREAM_TAP_EN
    , .stream_bits(stream_bits), .stream_valid(stream_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected value is the nearest in-range value, so it equals obs exactly when obs is inside.
  task automatic check_range(input string tag, input int v, input int lo, input int hi);
    int e;
    e = (v < lo) ? lo : ((v > hi) ? hi : v);
    check(tag, 64'(v), 64'(e));
  endtask

  function automatic logic [CHANNELS*WIDTH-1:0] rep(input int p);
    logic [CHANNELS*WIDTH-1:0] v;
    for (int c = 0; c < CHANNELS; c++) v[c*WIDTH +: WIDTH] = WIDTH'(p);
    return v;
  endfunction

  function automatic logic [CHANNELS*WIDTH-1:0] rnd_probs();
    logic [CHANNELS*WIDTH-1:0] v;
    for (int c = 0; c < CHANNELS; c++) v[c*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  function automatic int chan(input logic [CHANNELS*LEN_W-1:0] r, input int c);
    return int'(r[c*LEN_W +: LEN_W]);
  endfunction

  // One run: start at a negedge, then observe l+1 (or abort_at) cycles plus a short tail.
  // stray_at issues a len=0 start during RUN; noisy also scrambles inputs, pairs abort with
  // the accepted start, and pulses abort in the DONE cycle.
  task automatic run(input int l, input logic [1:0] m,
                     input logic [CHANNELS*WIDTH-1:0] pa, input logic [CHANNELS*WIDTH-1:0] pb,
                     input int abort_at, input int stray_at, input bit noisy,
                     output logic [CHANNELS*LEN_W-1:0] res);
    int busy_n, last_busy, done_n, done_at, stop, exp_len;
    logic err0;
    logic [CHANNELS*LEN_W-1:0] at_done;
`ifdef SC_STREAM_TAP_EN
    int pop [CHANNELS];
    for (int c = 0; c < CHANNELS; c++) pop[c] = 0;
`endif
    busy_n = 0; last_busy = 0; done_n = 0; done_at = 0; at_done = '0;
    exp_len = (abort_at > 0) ? abort_at : l;
    stop = exp_len + 4;
    @(negedge clk);
    err0   = err;
    start  = 1'b1;
    len    = LEN_W'(l);
    mode   = m;
    prob_a = pa;
    prob_b = pb;
    abort  = noisy;
    for (int j = 1; j <= stop; j++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (busy) begin busy_n++; last_busy = j; end
      if (done) begin done_n++; done_at = j; at_done = result; end
`ifdef SC_STREAM_TAP_EN
      if (stream_valid)
        for (int c = 0; c < CHANNELS; c++) pop[c] += int'(stream_bits[c]);
`endif
      if (noisy) begin
        len    = LEN_W'($urandom);
        mode   = 2'($urandom);
        prob_a = rnd_probs();
        prob_b = rnd_probs();
        if (j == l + 1) abort = 1'b1;
      end
      if (j == stray_at) begin start = 1'b1; len = '0; end
      if (j == abort_at) abort = 1'b1;
    end
    check("busy_cycles", 64'(busy_n), 64'(exp_len));
    check("busy_last", 64'(last_busy), 64'(exp_len));
    check("done_pulses", 64'(done_n), (abort_at > 0) ? 64'd0 : 64'd1);
    if (abort_at == 0) begin
      check("done_cycle", 64'(done_at), 64'(l + 1));
      check("result_hold", 64'(result), 64'(at_done));
    end
    check("err_unchanged", 64'(err), 64'(err0));
`ifdef SC_STREAM_TAP_EN
    for (int c = 0; c < CHANNELS; c++) check("tap_popcount", 64'(pop[c]), 64'(chan(result, c)));
`endif
    res = result;
    $display("run len=%0d mode=%0d abort_at=%0d stray_at=%0d noisy=%0d result=%h",
             l, m, abort_at, stray_at, noisy, result);
  endtask

  initial begin
    logic [CHANNELS*LEN_W-1:0] r_pass, r, r1, r2, r_hold;
    logic [CHANNELS*WIDTH-1:0] pa, pb;
    int l, ab, busy_seen, done_seen;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    // Probability 0 on A makes every AND output zero regardless of B.
    run(4096, 2'b00, rep(0), rnd_probs(), 0, 0, 1'b0, r);
    for (int c = 0; c < CHANNELS; c++) check("and_zero", 64'(chan(r, c)), 64'd0);

    run(4096, 2'b11, rep(128), rep(0), 0, 0, 1'b0, r_pass);
    for (int c = 0; c < CHANNELS; c++) check_range("pass_half", chan(r_pass, c), 1920, 2176);

    run(4096, 2'b00, rep(128), rep(128), 0, 0, 1'b0, r);
    for (int c = 0; c < CHANNELS; c++) check_range("and_quarter", chan(r, c), 928, 1120);

    // XOR with an all-zero B stream reproduces the pass-A counts exactly.
    run(4096, 2'b10, rep(128), rep(0), 0, 0, 1'b0, r);
    check("xor_b0_eq_pass", 64'(r), 64'(r_pass));

    run(4096, 2'b01, rep(255), rep(0), 0, 0, 1'b0, r);
    for (int c = 0; c < CHANNELS; c++) check_range("mux_half", chan(r, c), 1920, 2176);
    r_hold = r;

    // Zero-length start: err, no run, result untouched.
    @(negedge clk);
    start = 1'b1;
    len = '0;
    busy_seen = 0;
    done_seen = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("zero_len_err", 64'(err), 64'd1);
    check("zero_len_busy", 64'(busy_seen), 64'd0);
    check("zero_len_done", 64'(done_seen), 64'd0);
    check("zero_len_result", 64'(result), 64'(r_hold));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_clears_err", 64'(err), 64'd0);
    check("reset_clears_result", 64'(result), 64'd0);

    // Abort at run cycle 500 with a stray start at 200: partial counts equal a 500-cycle run.
    pa = rnd_probs();
    run(1000, 2'b11, pa, rep(0), 500, 200, 1'b0, r1);
    for (int c = 0; c < CHANNELS; c++) check_range("abort_bound", chan(r1, c), 0, 500);
    run(500, 2'b11, pa, rep(0), 0, 0, 1'b0, r2);
    check("abort_prefix", 64'(r1), 64'(r2));

    for (int it = 0; it < 6; it++) begin
      l  = $urandom_range(1, 400);
      mode = 2'($urandom);
      pa = rnd_probs();
      pb = rnd_probs();
      run(l, mode, pa, pb, 0, 0, 1'b0, r1);
      for (int c = 0; c < CHANNELS; c++) check_range("len_bound", chan(r1, c), 0, l);
      run(l, mode, pa, pb, 0, $urandom_range(1, l), 1'b1, r2);
      check("deterministic", 64'(r2), 64'(r1));
      ab = $urandom_range(1, l);
      run(l, mode, pa, pb, ab, 0, 1'b0, r1);
      run(ab, mode, pa, pb, 0, 0, 1'b0, r2);
      check("rand_abort_prefix", 64'(r1), 64'(r2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
